// File: rtl/farm_sensor_conditioner.sv
// farm_sensor_conditioner
//
// Turns the raw farm-road inductive-loop detector into the clean request
// used by the main/farm traffic-light controller. The raw level is
// synchronised, debounced and held across short detection gaps. A loop that
// stays occupied for too long is parked in a fault state, so the main road
// is never starved. Arrivals are counted until the farm phase is next served.
//
// Ports:
//   clk            in   system clock, everything on the rising edge
//   reset          in   synchronous, active-low reset
//   loop_raw       in   raw loop detector level (asynchronous, may bounce)
//   farm_light     in   controller's Farm_road lamp code (RED=0, YELLOW=1, GREEN=2)
//   car_farm_road  out  conditioned request to the controller
//   stuck_fault    out  high while the loop is considered stuck
//   car_count      out  arrivals since the farm phase was last served (saturates at 15)

module farm_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int STUCK_CYCLES    = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       loop_raw,
    input  logic [1:0] farm_light,
    output logic       car_farm_road,
    output logic       stuck_fault,
    output logic [3:0] car_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [1:0]  LIGHT_RED    = 2'd0;
    localparam logic [1:0]  LIGHT_YELLOW = 2'd1;
    localparam logic [15:0] DB_LAST      = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HOLD_LOAD    = 16'(HOLD_CYCLES);
    localparam logic [15:0] STUCK_LIMIT  = 16'(STUCK_CYCLES);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        loopDb_q, loopDb_d;
    logic        loopDbPrev_q, loopDbPrev_d;
    logic [15:0] dbCnt_q, dbCnt_d;
    logic [15:0] holdCnt_q, holdCnt_d;
    logic [15:0] stuckCnt_q, stuckCnt_d;
    logic [15:0] stuckInc;
    logic [1:0]  farmLight_q, farmLight_d;
    logic [3:0]  carCount_q, carCount_d;
    state_t      state_q, state_d;
    logic        arrival;
    logic        served;

    // Next-state logic for the synchroniser, debouncer, arrival counter and FSM.
    // The debounce counter only runs while the synchronised level disagrees
    // with the debounced level; it toggles the debounced level on the final
    // disagreeing cycle, so pulses shorter than DEBOUNCE_CYCLES never get through.
    always_comb begin
        sync1_d      = loop_raw;
        sync2_d      = sync1_q;
        loopDb_d     = loopDb_q;
        dbCnt_d      = '0;
        loopDbPrev_d = loopDb_q;
        farmLight_d  = farm_light;
        carCount_d   = carCount_q;
        state_d      = state_q;
        holdCnt_d    = holdCnt_q;
        stuckCnt_d   = stuckCnt_q;
        stuckInc     = stuckCnt_q + 16'd1;

        if (sync2_q != loopDb_q) begin
            if (dbCnt_q >= DB_LAST) begin
                loopDb_d = ~loopDb_q;
                dbCnt_d  = '0;
            end else begin
                dbCnt_d = dbCnt_q + 16'd1;
            end
        end

        // A stuck loop must not keep inflating the queue, so FAULT masks arrivals.
        arrival = loopDb_q && !loopDbPrev_q && (state_q != FAULT);
        served  = (farmLight_q == LIGHT_YELLOW) && (farm_light == LIGHT_RED);

        if (served) begin
            carCount_d = arrival ? 4'd1 : 4'd0;
        end else if (arrival && (carCount_q != 4'd15)) begin
            carCount_d = carCount_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (loopDb_q) begin
                    state_d    = PRESENT;
                    stuckCnt_d = '0;
                end
            end
            PRESENT: begin
                stuckCnt_d = stuckInc;
                if (!loopDb_q) begin
                    state_d   = HOLD;
                    holdCnt_d = HOLD_LOAD;
                end else if (stuckInc >= STUCK_LIMIT) begin
                    state_d = FAULT;
                end
            end
            HOLD: begin
                if (loopDb_q) begin
                    state_d    = PRESENT;
                    stuckCnt_d = '0;
                end else begin
                    holdCnt_d = holdCnt_q - 16'd1;
                    if (holdCnt_q <= 16'd1) begin
                        state_d   = IDLE;
                        holdCnt_d = '0;
                    end
                end
            end
            FAULT: begin
                if (!loopDb_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state lives here; an active-low reset sampled on the clock edge
    // returns everything to its idle values, including mid-operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            loopDb_q     <= 1'b0;
            loopDbPrev_q <= 1'b0;
            dbCnt_q      <= '0;
            holdCnt_q    <= '0;
            stuckCnt_q   <= '0;
            farmLight_q  <= LIGHT_RED;
            carCount_q   <= '0;
            state_q      <= IDLE;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            loopDb_q     <= loopDb_d;
            loopDbPrev_q <= loopDbPrev_d;
            dbCnt_q      <= dbCnt_d;
            holdCnt_q    <= holdCnt_d;
            stuckCnt_q   <= stuckCnt_d;
            farmLight_q  <= farmLight_d;
            carCount_q   <= carCount_d;
            state_q      <= state_d;
        end
    end

    // Moore outputs decoded straight from the state register.
    assign car_farm_road = (state_q == PRESENT) || (state_q == HOLD);
    assign stuck_fault   = (state_q == FAULT);
    assign car_count     = carCount_q;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// tb_farm_sensor_conditioner
//
// Directed bench for farm_sensor_conditioner with DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=8 and STUCK_CYCLES=50. Inputs change 1 time unit after a
// rising edge and outputs are sampled at that same point.
//
// Hand-derived timing at these settings: if loop_raw is high at edge E0, then
// loop_db rises at E5 and the request rises at E6. car_count also updates at E6.
// After loop_raw is low at edge F0, loop_db falls at F5 and HOLD starts at F6.
// The request then drops at F14.

module tb_farm_sensor_conditioner;

    logic       clk;
    logic       reset;
    logic       loop_raw;
    logic [1:0] farm_light;
    logic       car_farm_road;
    logic       stuck_fault;
    logic [3:0] car_count;

    int checks = 0;
    int errors = 0;

    farm_sensor_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .STUCK_CYCLES   (50)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .loop_raw     (loop_raw),
        .farm_light   (farm_light),
        .car_farm_road(car_farm_road),
        .stuck_fault  (stuck_fault),
        .car_count    (car_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle just past the last one.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One full arrival: loop high long enough to debounce, then low until idle again.
    task automatic oneArrival();
        loop_raw = 1'b1;
        applyStimulus(6);
        loop_raw = 1'b0;
        applyStimulus(16);
    endtask

    initial begin
        reset      = 1'b0;
        loop_raw   = 1'b0;
        farm_light = 2'd0;

        // Reset held for three edges with the loop empty.
        applyStimulus(3);
        checkOutput("reset_req", 16'(car_farm_road), 16'd0);
        checkOutput("reset_fault", 16'(stuck_fault), 16'd0);
        checkOutput("reset_count", 16'(car_count), 16'd0);
        reset = 1'b1;
        applyStimulus(3);
        checkOutput("idle_req", 16'(car_farm_road), 16'd0);

        // Clean arrival held for 20 edges, then released.
        $display("[TB] clean arrival");
        loop_raw = 1'b1;
        applyStimulus(6);
        checkOutput("rise_before_E6", 16'(car_farm_road), 16'd0);
        checkOutput("count_before_E6", 16'(car_count), 16'd0);
        applyStimulus(1);
        checkOutput("rise_at_E6", 16'(car_farm_road), 16'd1);
        checkOutput("count_after_arrival", 16'(car_count), 16'd1);
        applyStimulus(13);
        checkOutput("held_at_E19", 16'(car_farm_road), 16'd1);
        loop_raw = 1'b0;
        applyStimulus(14);
        checkOutput("hold_at_F13", 16'(car_farm_road), 16'd1);
        applyStimulus(1);
        checkOutput("drop_at_F14", 16'(car_farm_road), 16'd0);
        checkOutput("count_kept", 16'(car_count), 16'd1);

        // Serve the farm phase to clear the count.
        farm_light = 2'd1;
        applyStimulus(1);
        farm_light = 2'd0;
        applyStimulus(1);
        checkOutput("served_clear_1", 16'(car_count), 16'd0);

        // Bounce rejection: 3-high / 3-low pulses never debounce.
        $display("[TB] bounce rejection");
        for (int i = 0; i < 10; i++) begin
            loop_raw = 1'b1;
            applyStimulus(3);
            loop_raw = 1'b0;
            applyStimulus(3);
            checkOutput("bounce_req", 16'(car_farm_road), 16'd0);
        end
        applyStimulus(6);
        checkOutput("bounce_req_final", 16'(car_farm_road), 16'd0);
        checkOutput("bounce_count", 16'(car_count), 16'd0);

        // Gap bridging: loop drops long enough to debounce low, returns during HOLD.
        $display("[TB] gap bridging");
        loop_raw = 1'b1;
        applyStimulus(7);
        checkOutput("gap_first_req", 16'(car_farm_road), 16'd1);
        applyStimulus(3);
        loop_raw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1);
            checkOutput("gap_req_low_phase", 16'(car_farm_road), 16'd1);
        end
        loop_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("gap_req_high_phase", 16'(car_farm_road), 16'd1);
        end
        checkOutput("gap_count", 16'(car_count), 16'd2);
        loop_raw = 1'b0;
        applyStimulus(20);
        checkOutput("gap_release", 16'(car_farm_road), 16'd0);

        farm_light = 2'd1;
        applyStimulus(1);
        farm_light = 2'd0;
        applyStimulus(1);
        checkOutput("served_clear_2", 16'(car_count), 16'd0);

        // Stuck loop: PRESENT entered at E6, FAULT after 50 cycles at E56.
        $display("[TB] stuck loop");
        loop_raw = 1'b1;
        applyStimulus(56);
        checkOutput("stuck_req_E55", 16'(car_farm_road), 16'd1);
        checkOutput("stuck_fault_E55", 16'(stuck_fault), 16'd0);
        applyStimulus(1);
        checkOutput("stuck_req_E56", 16'(car_farm_road), 16'd0);
        checkOutput("stuck_fault_E56", 16'(stuck_fault), 16'd1);
        checkOutput("stuck_count", 16'(car_count), 16'd1);
        loop_raw = 1'b0;
        applyStimulus(6);
        checkOutput("fault_held_F5", 16'(stuck_fault), 16'd1);
        applyStimulus(1);
        checkOutput("fault_clear_F6", 16'(stuck_fault), 16'd0);
        loop_raw = 1'b1;
        applyStimulus(7);
        checkOutput("fresh_req", 16'(car_farm_road), 16'd1);
        checkOutput("fresh_count", 16'(car_count), 16'd2);
        loop_raw = 1'b0;
        applyStimulus(20);
        checkOutput("fresh_release", 16'(car_farm_road), 16'd0);

        // Saturation then served clear through GREEN -> YELLOW -> RED.
        $display("[TB] saturation and served clear");
        farm_light = 2'd1;
        applyStimulus(1);
        farm_light = 2'd0;
        applyStimulus(1);
        checkOutput("served_clear_3", 16'(car_count), 16'd0);
        for (int i = 0; i < 17; i++) begin
            oneArrival();
        end
        checkOutput("saturated", 16'(car_count), 16'd15);
        farm_light = 2'd2;
        applyStimulus(1);
        farm_light = 2'd1;
        applyStimulus(1);
        checkOutput("yellow_no_clear", 16'(car_count), 16'd15);
        farm_light = 2'd0;
        applyStimulus(1);
        checkOutput("red_clears", 16'(car_count), 16'd0);

        // Arrival on the same edge as YELLOW -> RED leaves a count of one.
        $display("[TB] coincident arrival and served");
        oneArrival();
        oneArrival();
        checkOutput("pre_coincident", 16'(car_count), 16'd2);
        farm_light = 2'd1;
        applyStimulus(1);
        loop_raw = 1'b1;
        applyStimulus(6);
        checkOutput("coincident_pending", 16'(car_count), 16'd2);
        farm_light = 2'd0;
        applyStimulus(1);
        checkOutput("coincident_count", 16'(car_count), 16'd1);
        applyStimulus(3);

        // Reset while in HOLD clears everything on the next edge.
        $display("[TB] reset during hold");
        loop_raw = 1'b0;
        applyStimulus(8);
        checkOutput("hold_before_reset", 16'(car_farm_road), 16'd1);
        checkOutput("count_before_reset", 16'(car_count), 16'd1);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("midreset_req", 16'(car_farm_road), 16'd0);
        checkOutput("midreset_fault", 16'(stuck_fault), 16'd0);
        checkOutput("midreset_count", 16'(car_count), 16'd0);
        reset = 1'b1;
        applyStimulus(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
